imm_extract_pipe: RTL and testbench
===================================

// Module: imm_extract_pipe
// PURPOSE
//  Decode-stage immediate unit: takes raw 32-bit RV32/RV64 instruction words, classifies format,
//  extracts and sign/zero-extends the immediate to XLEN. Elastic valid/ready pipeline of 1 or 2
//  stages with flush; carries a sideband tag (PC/ROB id). Sits between fetch queue and decode/regread.
// PARAMETERS
//  XLEN       32  datapath width; immediates extended to XLEN (32 or 64)
//  STAGES     1   pipeline depth, 1 or 2 (2: format decode in stage 1, extension in stage 2)
//  TAG_W      32  sideband tag width, passed through unmodified
//  ENABLE_FP  1   1: LOAD-FP/STORE-FP legal; 0: flagged illegal
// PORTS
//  clock      in   1       single clock, all state on rising edge
//  reset      in   1       synchronous, active-low
//  flush      in   1       drop all in-flight entries
//  in_valid   in   1       instruction offered
//  in_ready   out  1       unit accepts this cycle
//  in_instr   in   32      raw instruction word
//  in_tag     in   TAG_W   sideband tag
//  out_valid  out  1       result available
//  out_ready  in   1       consumer accepts this cycle
//  out_imm    out  XLEN    extended immediate
//  out_fmt    out  3       IMM_NONE/I/S/B/U/J/Z
//  out_illegal out 1       unrecognised or disabled opcode
//  out_tag    out  TAG_W   tag of the result
// BEHAVIOUR
//  - Reset (reset==0 at edge): all stage valids 0, data regs 0; out_valid=0, out_imm=0, out_fmt=NONE,
//    out_illegal=0, out_tag=0. in_ready=1 in first cycle after reset release.
//  - Transfer when valid&&ready at edge. Stage k advances if its successor is empty or draining;
//    in_ready = !s0_valid || advance0 (combinational from out_ready). Latency = STAGES cycles when
//    unstalled; throughput 1/cycle; order preserved, no loss/duplication under backpressure.
//  - Held output stable (imm/fmt/illegal/tag) while out_valid && !out_ready.
//  - flush: all valids cleared at that edge; an input handshaking in the same cycle is discarded.
//    flush has priority over advance; reset priority over flush.
//  - Format by opcode[6:0]: OP-IMM 0010011, LOAD 0000011, JALR 1100111 -> I; STORE 0100011 -> S;
//    BRANCH 1100011 -> B; LUI 0110111, AUIPC 0010111 -> U; JAL 1101111 -> J; SYSTEM 1110011 -> Z;
//    LOAD-FP 0000111 -> I; STORE-FP 0100111 -> S (FP store uses S-type split immediate).
//    OP 0110011, OP-FP 1010011, MISC-MEM 0001111 -> NONE, imm=0, illegal=0.
//  - Any other opcode, opcode[1:0]!=2'b11, or FP opcode with ENABLE_FP=0 -> NONE, imm=0, illegal=1.
//  - Extraction: I {instr[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0};
//    U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; all sign-extended from instr[31] to XLEN
//    (U included: LUI 0x80000 at XLEN=64 -> 0xFFFFFFFF80000000). Z = instr[19:15] zero-extended.
//  - OP-IMM shifts: full I immediate delivered; shamt masking is the ALU's job.
// STRUCTURE
//  - Shared constants header: opcode defines (existing format macros plus LOAD-FP/STORE-FP/OP/
//    OP-FP/MISC-MEM) and IMM_* 3-bit format codes; reused by decoder and hazard unit.
//  - Sub-module imm_format_decode (combinational: opcode + ENABLE_FP -> fmt, illegal) instantiated
//    once; extension mux and elastic stage registers in this module via generate on STAGES.
// TESTING (run for STAGES=1,2; XLEN=32,64)
//  - addi x1,x0,-1 0xFFF00093 -> after STAGES cycles imm=all ones, fmt=I, illegal=0.
//  - sw x1,-4(x2) 0xFE112E23 -> imm=-4 (0xFFFFFFFC @32), fmt=S; beq offset -8 -> imm=-8, fmt=B.
//  - lui 0x12345 0x123452B7 -> 0x12345000; lui 0x80000 @XLEN=64 -> 0xFFFFFFFF80000000, fmt=U.
//  - csrrwi x0,mstatus,5 0x3002D073 -> imm=5, fmt=Z; 0x00000000 -> illegal=1, imm=0;
//    flw 0x00452007 with ENABLE_FP=0 -> illegal=1.
//  - Stream 6 tagged instrs, out_ready low 3 cycles mid-stream -> in_ready drops when full,
//    outputs held stable, all 6 tags out in order exactly once.
//  - flush with 2 in flight plus concurrent input -> out_valid=0 next cycle, none emitted;
//    reset asserted mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/imm_extract_pipe_pkg.sv
// Shared constants for the decode-stage immediate unit: RV opcode values,
// the 3-bit immediate format codes, and the immediate extraction helper.
// Reused by the format decoder, the immediate pipeline and the hazard unit.
package imm_extract_pipe_pkg;

  // Opcodes that carry an immediate
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  // Legal opcodes without an immediate
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_fmt_e;

  // Builds the immediate at 64 bits; callers truncate to XLEN, which keeps the
  // sign extension correct for XLEN=32 as well. Opcode bits are not needed.
  function automatic logic [63:0] extend_imm(input logic [31:7] instr, input imm_fmt_e fmt);
    logic [63:0] r;
    r = '0;
    case (fmt)
      IMM_I: r = {{52{instr[31]}}, instr[31:20]};
      IMM_S: r = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: r = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: r = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_J: r = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z: r = {59'b0, instr[19:15]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_extract_pipe_format_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode  in  7  instruction bits [6:0]
//   fmt     out 3  immediate format (IMM_*)
//   illegal out 1  unrecognised opcode, or FP opcode with ENABLE_FP=0
module imm_format_decode
  import imm_extract_pipe_pkg::*;
#(
  parameter int ENABLE_FP = 1
) (
  input  logic [6:0] opcode,
  output imm_fmt_e   fmt,
  output logic       illegal
);

  always_comb begin
    fmt     = IMM_NONE;
    illegal = 1'b0;
    // Every listed opcode ends in 2'b11, so compressed encodings fall to default.
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      OPC_SYSTEM:                     fmt = IMM_Z;
      OPC_LOAD_FP: begin
        if (ENABLE_FP != 0) fmt = IMM_I;
        else                illegal = 1'b1;
      end
      OPC_STORE_FP: begin
        if (ENABLE_FP != 0) fmt = IMM_S;
        else                illegal = 1'b1;
      end
      OPC_OP, OPC_OP_FP, OPC_MISC_MEM: fmt = IMM_NONE;
      default:                         illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extract_pipe.sv
// Decode-stage immediate unit: classifies the instruction format and delivers
// the XLEN-extended immediate through an elastic pipeline of 1 or 2 stages.
// Ports:
//   clock, reset (sync, active-low), flush (drops all in-flight entries)
//   in_valid/in_ready/in_instr/in_tag     upstream handshake and payload
//   out_valid/out_ready                   downstream handshake
//   out_imm/out_fmt/out_illegal/out_tag   result payload
// Handshake: a transfer happens on a rising edge where valid && ready. A
// producer holding valid keeps its payload stable until accepted; ready may
// depend combinationally on the downstream ready (in_ready follows out_ready).
// With STAGES=2 the format is decoded in stage 1 and the immediate extended in
// stage 2.
module imm_extract_pipe
  import imm_extract_pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STAGES    = 1,
  parameter int TAG_W     = 32,
  parameter int ENABLE_FP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  imm_fmt_e dec_fmt;
  logic     dec_illegal;

  imm_format_decode #(.ENABLE_FP(ENABLE_FP)) u_decode (
    .opcode  (in_instr[6:0]),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  if (STAGES == 1) begin : g_one
    logic             s0_valid;
    logic [XLEN-1:0]  s0_imm;
    imm_fmt_e         s0_fmt;
    logic             s0_illegal;
    logic [TAG_W-1:0] s0_tag;

    assign in_ready = !s0_valid || out_ready;

    always_ff @(posedge clock) begin
      if (!reset) begin
        s0_valid   <= 1'b0;
        s0_imm     <= '0;
        s0_fmt     <= IMM_NONE;
        s0_illegal <= 1'b0;
        s0_tag     <= '0;
      end else begin
        if (flush)         s0_valid <= 1'b0;
        else if (in_ready) s0_valid <= in_valid;
        // Payload only moves on an accepted, non-flushed input so a stalled
        // output stays stable.
        if (!flush && in_ready && in_valid) begin
          s0_imm     <= XLEN'(extend_imm(in_instr[31:7], dec_fmt));
          s0_fmt     <= dec_fmt;
          s0_illegal <= dec_illegal;
          s0_tag     <= in_tag;
        end
      end
    end

    assign out_valid   = s0_valid;
    assign out_imm     = s0_imm;
    assign out_fmt     = s0_fmt;
    assign out_illegal = s0_illegal;
    assign out_tag     = s0_tag;
  end else begin : g_two
    logic             s0_valid;
    logic [31:7]      s0_instr;
    imm_fmt_e         s0_fmt;
    logic             s0_illegal;
    logic [TAG_W-1:0] s0_tag;
    logic             s1_valid;
    logic [XLEN-1:0]  s1_imm;
    imm_fmt_e         s1_fmt;
    logic             s1_illegal;
    logic [TAG_W-1:0] s1_tag;
    logic             advance1;

    // Stage 1 can take a new entry when stage 2 is empty or draining.
    assign advance1 = !s1_valid || out_ready;
    assign in_ready = !s0_valid || advance1;

    always_ff @(posedge clock) begin
      if (!reset) begin
        s0_valid   <= 1'b0;
        s0_instr   <= '0;
        s0_fmt     <= IMM_NONE;
        s0_illegal <= 1'b0;
        s0_tag     <= '0;
        s1_valid   <= 1'b0;
        s1_imm     <= '0;
        s1_fmt     <= IMM_NONE;
        s1_illegal <= 1'b0;
        s1_tag     <= '0;
      end else begin
        if (flush)         s1_valid <= 1'b0;
        else if (advance1) s1_valid <= s0_valid;
        if (!flush && advance1 && s0_valid) begin
          s1_imm     <= XLEN'(extend_imm(s0_instr, s0_fmt));
          s1_fmt     <= s0_fmt;
          s1_illegal <= s0_illegal;
          s1_tag     <= s0_tag;
        end

        if (flush)         s0_valid <= 1'b0;
        else if (in_ready) s0_valid <= in_valid;
        if (!flush && in_ready && in_valid) begin
          s0_instr   <= in_instr[31:7];
          s0_fmt     <= dec_fmt;
          s0_illegal <= dec_illegal;
          s0_tag     <= in_tag;
        end
      end
    end

    assign out_valid   = s1_valid;
    assign out_imm     = s1_imm;
    assign out_fmt     = s1_fmt;
    assign out_illegal = s1_illegal;
    assign out_tag     = s1_tag;
  end

endmodule

// File: tb/tb_imm_extract_pipe.sv
// Two instances share the input payload:
//   a: XLEN=32, STAGES=1, ENABLE_FP=0
//   b: XLEN=64, STAGES=2, ENABLE_FP=1
// Directed vectors drive both; stream and flush scenarios drive one at a time.
module tb_imm_extract_pipe;

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;
  localparam logic [2:0] F_Z    = 3'd6;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, flush, in_valid, out_ready, en_a, en_b, sel_b;
  logic [31:0] in_instr;
  logic [15:0] in_tag;
  logic        in_valid_a, in_valid_b;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_imm_a;
  logic [2:0]  out_fmt_a;
  logic [15:0] out_tag_a;
  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_imm_b;
  logic [2:0]  out_fmt_b;
  logic [15:0] out_tag_b;

  assign in_valid_a = in_valid & en_a;
  assign in_valid_b = in_valid & en_b;

  imm_extract_pipe #(.XLEN(32), .STAGES(1), .TAG_W(16), .ENABLE_FP(0)) dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
    .out_fmt(out_fmt_a), .out_illegal(out_illegal_a), .out_tag(out_tag_a)
  );

  imm_extract_pipe #(.XLEN(64), .STAGES(2), .TAG_W(16), .ENABLE_FP(1)) dut_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
    .out_fmt(out_fmt_b), .out_illegal(out_illegal_b), .out_tag(out_tag_b)
  );

  // selected-instance view for single-instance scenarios
  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_tag;
  logic [63:0] s_out_imm;
  always_comb begin
    s_in_ready  = sel_b ? in_ready_b  : in_ready_a;
    s_out_valid = sel_b ? out_valid_b : out_valid_a;
    s_out_tag   = sel_b ? out_tag_b   : out_tag_a;
    s_out_imm   = sel_b ? out_imm_b   : {32'b0, out_imm_a};
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // driver: one instruction into both instances, unstalled
  task automatic run_one(input string name, input logic [31:0] instr, input logic [15:0] tag,
                         input logic [63:0] exp_imm, input logic [2:0] exp_fmt,
                         input logic exp_ill, input logic fp);
    @(negedge clock);
    en_a = 1'b1; en_b = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = instr; in_tag = tag;
    #1;
    check({name, ".a_in_ready"}, 64'(in_ready_a), 64'd1);
    @(negedge clock);
    in_valid = 1'b0; in_instr = 32'h0;
    check({name, ".a_valid"}, 64'(out_valid_a), 64'd1);
    check({name, ".a_imm"}, 64'(out_imm_a), fp ? 64'd0 : {32'b0, exp_imm[31:0]});
    check({name, ".a_fmt"}, 64'(out_fmt_a), fp ? 64'(F_NONE) : 64'(exp_fmt));
    check({name, ".a_ill"}, 64'(out_illegal_a), fp ? 64'd1 : 64'(exp_ill));
    check({name, ".a_tag"}, 64'(out_tag_a), 64'(tag));
    check({name, ".b_valid_early"}, 64'(out_valid_b), 64'd0);
    @(negedge clock);
    check({name, ".b_valid"}, 64'(out_valid_b), 64'd1);
    check({name, ".b_imm"}, out_imm_b, exp_imm);
    check({name, ".b_fmt"}, 64'(out_fmt_b), 64'(exp_fmt));
    check({name, ".b_ill"}, 64'(out_illegal_b), 64'(exp_ill));
    check({name, ".b_tag"}, 64'(out_tag_b), 64'(tag));
    check({name, ".a_drained"}, 64'(out_valid_a), 64'd0);
  endtask

  // 6 tagged addi's, out_ready low for cycles 3..5
  task automatic stream(input logic sel);
    int sent, recv;
    logic saw_full, held_v;
    logic [15:0] held_tag, e;
    logic [63:0] held_imm;
    sent = 0; recv = 0; saw_full = 1'b0; held_v = 1'b0;
    held_tag = '0; held_imm = '0;
    exp_q.delete();
    @(negedge clock);
    sel_b = sel; en_a = !sel; en_b = sel;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      @(negedge clock);
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 6);
      in_instr  = {12'(sent + 1), 20'h00093};
      in_tag    = 16'(16'hA0 + sent);
      #1;
      if (held_v) begin
        check("stream.held_valid", 64'(s_out_valid), 64'd1);
        check("stream.held_tag", 64'(s_out_tag), 64'(held_tag));
        check("stream.held_imm", s_out_imm, held_imm);
      end
      if (s_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream.unexpected", 64'(s_out_tag), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("stream.tag", 64'(s_out_tag), 64'(e));
          check("stream.imm", s_out_imm, 64'(e - 16'h9F));
        end
        recv++;
      end
      held_v   = s_out_valid && !out_ready;
      held_tag = s_out_tag;
      held_imm = s_out_imm;
      if (in_valid && !s_in_ready) saw_full = 1'b1;
      if (in_valid && s_in_ready) begin
        exp_q.push_back(in_tag);
        sent++;
      end
    end
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream.recv", 64'(recv), 64'd6);
    check("stream.sent", 64'(sent), 64'd6);
    check("stream.leftover", 64'(exp_q.size()), 64'd0);
    check("stream.in_ready_dropped", 64'(saw_full), 64'd1);
  endtask

  // fill entries with out_ready low, then flush with a concurrent input
  task automatic flush_test(input logic sel, input int fill);
    @(negedge clock);
    sel_b = sel; en_a = !sel; en_b = sel; out_ready = 1'b0;
    for (int i = 0; i < fill; i++) begin
      in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 16'(16'hF0 + i);
      @(negedge clock);
    end
    in_valid = 1'b1; flush = 1'b1; in_instr = 32'h123452B7; in_tag = 16'hFE;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush.out_valid", 64'(s_out_valid), 64'd0);
    #1;
    check("flush.in_ready", 64'(s_in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("flush.none_emitted", 64'(s_out_valid), 64'd0);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, ".a_valid"}, 64'(out_valid_a), 64'd0);
    check({name, ".a_imm"}, 64'(out_imm_a), 64'd0);
    check({name, ".a_fmt"}, 64'(out_fmt_a), 64'(F_NONE));
    check({name, ".a_ill"}, 64'(out_illegal_a), 64'd0);
    check({name, ".a_tag"}, 64'(out_tag_a), 64'd0);
    check({name, ".b_valid"}, 64'(out_valid_b), 64'd0);
    check({name, ".b_imm"}, out_imm_b, 64'd0);
    check({name, ".b_fmt"}, 64'(out_fmt_b), 64'(F_NONE));
    check({name, ".b_ill"}, 64'(out_illegal_b), 64'd0);
    check({name, ".b_tag"}, 64'(out_tag_b), 64'd0);
    check({name, ".a_in_ready"}, 64'(in_ready_a), 64'd1);
    check({name, ".b_in_ready"}, 64'(in_ready_b), 64'd1);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    en_a = 1'b1; en_b = 1'b1; sel_b = 1'b0;
    in_instr = 32'h0; in_tag = 16'h0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b1;
    #1;
    check("reset.release_in_ready_a", 64'(in_ready_a), 64'd1);
    check("reset.release_in_ready_b", 64'(in_ready_b), 64'd1);

    run_one("addi",   32'hFFF00093, 16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, F_I,    1'b0, 1'b0);
    run_one("sw",     32'hFE112E23, 16'h0002, 64'hFFFF_FFFF_FFFF_FFFC, F_S,    1'b0, 1'b0);
    run_one("beq",    32'hFE000CE3, 16'h0003, 64'hFFFF_FFFF_FFFF_FFF8, F_B,    1'b0, 1'b0);
    run_one("lui",    32'h123452B7, 16'h0004, 64'h0000_0000_1234_5000, F_U,    1'b0, 1'b0);
    run_one("lui_hi", 32'h800002B7, 16'h0005, 64'hFFFF_FFFF_8000_0000, F_U,    1'b0, 1'b0);
    run_one("auipc",  32'h00001097, 16'h0006, 64'h0000_0000_0000_1000, F_U,    1'b0, 1'b0);
    run_one("jal",    32'hFFDFF06F, 16'h0007, 64'hFFFF_FFFF_FFFF_FFFC, F_J,    1'b0, 1'b0);
    run_one("csrrwi", 32'h3002D073, 16'h0008, 64'h0000_0000_0000_0005, F_Z,    1'b0, 1'b0);
    run_one("zero",   32'h00000000, 16'h0009, 64'h0,                   F_NONE, 1'b1, 1'b0);
    run_one("rvc",    32'h00000012, 16'h000A, 64'h0,                   F_NONE, 1'b1, 1'b0);
    run_one("add",    32'h002081B3, 16'h000B, 64'h0,                   F_NONE, 1'b0, 1'b0);
    run_one("flw",    32'h00452007, 16'h000C, 64'h0000_0000_0000_0004, F_I,    1'b0, 1'b1);
    run_one("fsw",    32'h00A12227, 16'h000D, 64'h0000_0000_0000_0004, F_S,    1'b0, 1'b1);

    stream(1'b0);
    stream(1'b1);

    flush_test(1'b0, 0);
    flush_test(1'b0, 1);
    flush_test(1'b1, 0);
    flush_test(1'b1, 2);

    // reset in the middle of traffic
    @(negedge clock);
    en_a = 1'b1; en_b = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h123452B7; in_tag = 16'h0077;
    repeat (2) @(negedge clock);
    check("midreset.a_busy", 64'(out_valid_a), 64'd1);
    check("midreset.b_busy", 64'(out_valid_b), 64'd1);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check_reset_vals("midreset");
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
